count_seq_ctrl: RTL
===================

// Module: count_seq_ctrl
// PURPOSE
//  Command-driven sequencer for the mod-N display counter datapath. Accepts op/arg
//  commands over valid/ready, paces steps with a CLK prescaler, and drives one-cycle
//  clear/load/inc/dec strobes to the counter while watching its value cnt_q.
//  Signals target reach with tc_pulse. Sits between pushbutton decode and the counter.
// PARAMETERS
//  MOD_N     100  counter modulus; legal values 0..MOD_N-1
//  PRESCALE  10   CLK cycles per step tick; PRESCALE >= 2
//  W         8    width of count, arg and load value
// PORTS
//  CLK         in   1  clock
//  RST         in   1  reset: synchronous, active-high
//  cmd_valid   in   1  command offered
//  cmd_ready   out  1  command accepted when cmd_valid & cmd_ready
//  cmd_op      in   3  0 NOP,1 CLEAR,2 LOAD,3 RUN_UP,4 RUN_DOWN,5 PAUSE,6 RESUME,7 ABORT
//  cmd_arg     in   W  load value (LOAD) or target (RUN_UP/RUN_DOWN)
//  cnt_q       in   W  current counter value
//  cnt_clr     out  1  one-cycle strobe: counter -> 0
//  cnt_load    out  1  one-cycle strobe: counter -> cnt_ld_val
//  cnt_ld_val  out  W  load value, valid while cnt_load=1
//  cnt_inc     out  1  one-cycle strobe: counter +1, MOD_N-1 wraps to 0
//  cnt_dec     out  1  one-cycle strobe: counter -1, 0 wraps to MOD_N-1
//  state       out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
//  tc_pulse    out  1  one-cycle pulse on target reached
//  cmd_err     out  1  one-cycle pulse on illegal/rejected command
// BEHAVIOUR
//  Reset: state=IDLE, all strobes/pulses 0, cnt_ld_val=0, prescaler=0, target=0, dir=up.
//   cmd_ready=0 while RST=1.
//  All outputs registered; an effect appears the cycle after acceptance.
//  cmd_ready = 1 in IDLE/RUN/PAUSE, 0 in DONE.
//  IDLE: CLEAR -> cnt_clr. LOAD arg<MOD_N -> cnt_load, cnt_ld_val=arg.
//   RUN_UP/RUN_DOWN arg<MOD_N -> latch target=arg and dir, prescaler=0, go RUN.
//   Any arg>=MOD_N -> cmd_err, no other effect. PAUSE/RESUME/ABORT/NOP -> no effect.
//  RUN: prescaler counts 0..PRESCALE-1; tick when it wraps (every PRESCALE cycles).
//   On tick: cnt_q==target -> go DONE, tc_pulse=1, no strobe; else one inc/dec strobe.
//   Target is checked before each step, so start with cnt_q==target -> DONE on first
//   tick, zero steps.
//   PAUSE -> go PAUSE, prescaler frozen. ABORT -> go IDLE, prescaler=0, no strobe.
//   CLEAR/LOAD/RUN_* -> cmd_err, ignored. RESUME/NOP ignored.
//  PAUSE: RESUME -> RUN, prescaler continues from frozen value. ABORT -> IDLE.
//   CLEAR/LOAD/RUN_* -> cmd_err. PAUSE/NOP ignored.
//  DONE: exactly one cycle, then IDLE; no command accepted.
//  Command accepted on a tick cycle: command wins. PAUSE/ABORT suppress that tick's
//   strobe and tc_pulse; other accepted commands let the tick proceed normally.
//  Never more than one of cnt_clr/load/inc/dec high in any cycle.
//  RST mid-operation: next cycle IDLE, no strobes; a pending tick is lost.
//  Tick counting is modulo-free: the controller never computes wrap. cnt_q is sampled
//   only on ticks, so a strobe always settles before the next tick (PRESCALE>=2).
// TESTING (bench includes a behavioural mod-MOD_N counter driven by strobes; PRESCALE=4)
//  Reset: RST 3 cycles -> state=0, strobes 0, cmd_ready 0 during and 1 after.
//  LOAD 42 -> cnt_load=1, cnt_ld_val=42 one cycle later, cnt_q=42; LOAD 150 ->
//   cmd_err, no strobe.
//  cnt_q=97, RUN_UP 2 -> cnt_inc every 4 cycles, cnt_q 98,99,0,1,2; tc_pulse at
//   6th tick; DONE 1 cycle; then IDLE.
//  cnt_q=1, RUN_DOWN 98 -> 3 cnt_dec strobes (0,99,98); tc_pulse on 4th tick.
//   RUN_UP 5 with cnt_q=5 -> tc_pulse at first tick, no inc.
//  RUN_UP 50 from 10, PAUSE after 2 steps, hold 20 cycles -> no strobes.
//   RESUME -> next inc lands at remaining prescale phase. LOAD while paused -> cmd_err.
//  PAUSE on exact tick cycle -> no inc. ABORT in RUN -> IDLE, cnt_q unchanged.
//   RST mid-RUN -> IDLE next cycle, no strobe.

Source files
------------

// File: rtl/count_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_ctrl
//  Description : Command-driven sequencer for the mod-N display counter.
//                Accepts op/arg commands over valid/ready, paces steps with a
//                clock prescaler and issues one-cycle clear/load/inc/dec
//                strobes while watching the counter value.
//  Revision    : 1.0  initial release
// ============================================================================
module count_seq_ctrl #(
  parameter int MOD_N    = 100,
  parameter int PRESCALE = 10,
  parameter int W        = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_arg,
  input  logic [W-1:0] cnt_q,
  output logic         cnt_clr,
  output logic         cnt_load,
  output logic [W-1:0] cnt_ld_val,
  output logic         cnt_inc,
  output logic         cnt_dec,
  output logic [1:0]   state,
  output logic         tc_pulse,
  output logic         cmd_err
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  // One extra bit so a modulus of 2**W still compares correctly.
  localparam logic [W:0]    MOD_N_EXT  = (W+1)'(MOD_N);

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_CLEAR    = 3'd1;
  localparam logic [2:0] OP_LOAD     = 3'd2;
  localparam logic [2:0] OP_RUN_UP   = 3'd3;
  localparam logic [2:0] OP_RUN_DOWN = 3'd4;
  localparam logic [2:0] OP_PAUSE    = 3'd5;
  localparam logic [2:0] OP_RESUME   = 3'd6;
  localparam logic [2:0] OP_ABORT    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [W-1:0]   target_q, target_d;
  logic           dir_up_q, dir_up_d;
  logic [W-1:0]   ld_val_q, ld_val_d;
  logic           clr_q, clr_d;
  logic           load_q, load_d;
  logic           inc_q, inc_d;
  logic           dec_q, dec_d;
  logic           tc_q, tc_d;
  logic           err_q, err_d;

  logic           accept;
  logic           arg_ok;
  logic           tick;
  logic           hold;

  // Ready follows the registered state; forced low while reset is held.
  assign cmd_ready = !RST && (state_q != ST_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign arg_ok    = ({1'b0, cmd_arg} < MOD_N_EXT);
  assign tick      = (presc_q == PRESC_LAST);

  // Next-state, prescaler and strobe decode; strobes default low every cycle.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    target_d = target_q;
    dir_up_d = dir_up_q;
    ld_val_d = ld_val_q;
    clr_d    = 1'b0;
    load_d   = 1'b0;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    tc_d     = 1'b0;
    err_d    = 1'b0;
    hold     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CLEAR: clr_d = 1'b1;
            OP_LOAD: begin
              if (arg_ok) begin
                load_d   = 1'b1;
                ld_val_d = cmd_arg;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_RUN_UP, OP_RUN_DOWN: begin
              if (arg_ok) begin
                target_d = cmd_arg;
                dir_up_d = (cmd_op == OP_RUN_UP);
                presc_d  = '0;
                state_d  = ST_RUN;
              end else begin
                err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        // A command on a tick cycle wins; PAUSE/ABORT swallow that tick.
        if (accept) begin
          case (cmd_op)
            OP_PAUSE: begin
              state_d = ST_PAUSE;
              hold    = 1'b1;
            end
            OP_ABORT: begin
              state_d = ST_IDLE;
              presc_d = '0;
              hold    = 1'b1;
            end
            OP_CLEAR, OP_LOAD, OP_RUN_UP, OP_RUN_DOWN: err_d = 1'b1;
            default: ;
          endcase
        end
        if (!hold) begin
          if (tick) begin
            presc_d = '0;
            // Target is checked before stepping, so an already-matching
            // counter finishes with zero steps.
            if (cnt_q == target_q) begin
              state_d = ST_DONE;
              tc_d    = 1'b1;
            end else begin
              inc_d = dir_up_q;
              dec_d = !dir_up_q;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end

      ST_PAUSE: begin
        if (accept) begin
          case (cmd_op)
            OP_RESUME: state_d = ST_RUN;
            OP_ABORT: begin
              state_d = ST_IDLE;
              presc_d = '0;
            end
            OP_CLEAR, OP_LOAD, OP_RUN_UP, OP_RUN_DOWN: err_d = 1'b1;
            default: ;
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, context and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      target_q <= '0;
      dir_up_q <= 1'b1;
      ld_val_q <= '0;
      clr_q    <= 1'b0;
      load_q   <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      target_q <= target_d;
      dir_up_q <= dir_up_d;
      ld_val_q <= ld_val_d;
      clr_q    <= clr_d;
      load_q   <= load_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      tc_q     <= tc_d;
      err_q    <= err_d;
    end
  end

  assign cnt_clr    = clr_q;
  assign cnt_load   = load_q;
  assign cnt_ld_val = ld_val_q;
  assign cnt_inc    = inc_q;
  assign cnt_dec    = dec_q;
  assign tc_pulse   = tc_q;
  assign cmd_err    = err_q;
  assign state      = state_q;

endmodule
`default_nettype wire
